bus_rr_arbiter: RTL and testbench

- Registered round-robin arbiter that shares the single CPU-side AHB master port among N requesters (TLB bus unit, L1 bus unit, external DMA, ...).
- Each requester uses a level req/ack handshake.
- Drives the select (grant_id) for the downstream AHB datapath mux.
- Guarantees ownership only changes on an idle, unlocked bus.
- A hold limit asks a long-running owner to yield when others are waiting.

---
 rtl/bus_rr_arbiter_pkg.sv | 15 +
 rtl/bus_rr_arbiter_rr_pick.sv | 34 +++
 rtl/bus_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the CPU-side AHB bus arbiter and the bus units that
// drive its requesters: arbiter state encoding and AHB htrans codes.
package bus_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request after last_owner,
// wrapping modulo N.
module bus_rr_arbiter_rr_pick #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_owner,
  output logic [IDW-1:0] winner,
  output logic           found
);

  int w_dist;
  int w_best;

  // NOTE: every output and temporary gets a default first so this block
  // can never infer a latch, whatever path the loop takes.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      // Distance from the slot just after last_owner; smaller wins.
      w_dist = (i + N - 1 - int'(last_owner)) % N;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin arbiter for the single CPU-side AHB master port.
// Ownership only changes once the bus is idle and unlocked.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N        = 3,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 64,
  parameter int CW       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   bus_req,
  output logic [N-1:0]   bus_ack,
  output logic [N-1:0]   yield_req,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  input  logic [1:0]     htrans,
  input  logic           hready,
  input  logic           hmastlock
);

  arb_state_e     r_state,       w_state_nxt;
  logic [N-1:0]   r_ack,         w_ack_nxt;
  logic [N-1:0]   r_yield,       w_yield_nxt;
  logic [IDW-1:0] r_grant_id,    w_grant_id_nxt;
  logic           r_grant_valid, w_grant_valid_nxt;
  logic [IDW-1:0] r_last_owner,  w_last_owner_nxt;
  logic [CW-1:0]  r_hold_cnt,    w_hold_cnt_nxt;

  logic [IDW-1:0] w_winner;
  logic           w_found;
  logic           w_owner_req;
  logic           w_others_wait;
  logic           w_bus_idle;
  logic           w_hold_hit;

  bus_rr_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req        (bus_req),
    .last_owner (r_last_owner),
    .winner     (w_winner),
    .found      (w_found)
  );

  // r_ack is the one-hot owner mask, so these need no index decode.
  assign w_owner_req   = |(bus_req & r_ack);
  assign w_others_wait = |(bus_req & ~r_ack);
  assign w_bus_idle    = (htrans == HTRANS_IDLE) && hready && !hmastlock;
  assign w_hold_hit    = (MAX_HOLD != 0) && (r_hold_cnt >= CW'(MAX_HOLD))
                         && !hmastlock && w_others_wait;

  always_comb begin
    w_state_nxt       = r_state;
    w_ack_nxt         = r_ack;
    w_yield_nxt       = r_yield;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_last_owner_nxt  = r_last_owner;
    w_hold_cnt_nxt    = r_hold_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt       = ARB_GRANT;
          w_ack_nxt         = N'(1) << w_winner;
          w_grant_id_nxt    = w_winner;
          w_grant_valid_nxt = 1'b1;
          w_hold_cnt_nxt    = '0;
        end
      end
      ARB_GRANT: begin
        if (r_hold_cnt != '1) w_hold_cnt_nxt = r_hold_cnt + CW'(1);
        if (!w_owner_req) begin
          w_state_nxt = ARB_RELEASE;
          w_ack_nxt   = '0;
          w_yield_nxt = '0;
        end else if (w_hold_hit) begin
          // Sticky: once asked, the owner keeps seeing the request.
          w_yield_nxt = r_ack;
        end
      end
      ARB_RELEASE: begin
        // grant_id is held here so the mux stays on the finishing owner.
        if (w_bus_idle) begin
          w_state_nxt       = ARB_IDLE;
          w_last_owner_nxt  = r_grant_id;
          w_grant_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ARB_IDLE;
      r_ack         <= '0;
      r_yield       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_last_owner  <= IDW'(N - 1);
      r_hold_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ack         <= w_ack_nxt;
      r_yield       <= w_yield_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_last_owner  <= w_last_owner_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
    end
  end

  assign bus_ack     = r_ack;
  assign yield_req   = r_yield;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;

  a_ack_onehot0 : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(r_ack));

  a_id_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_state != ARB_IDLE) |=> $stable(r_grant_id));

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (N=3, MAX_HOLD=8): grant latency,
// round-robin order, release gating, hold limit, lock and async reset.
module tb_bus_rr_arbiter;

  localparam int N        = 3;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;
  localparam int CW       = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   bus_req;
  logic [N-1:0]   bus_ack;
  logic [N-1:0]   yield_req;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic [1:0]     htrans;
  logic           hready;
  logic           hmastlock;

  int checks;
  int failures;

  bus_rr_arbiter #(
    .N        (N),
    .IDW      (IDW),
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_req     (bus_req),
    .bus_ack     (bus_ack),
    .yield_req   (yield_req),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .htrans      (htrans),
    .hready      (hready),
    .hmastlock   (hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("ack_onehot0", 32'($onehot0(bus_ack)), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] ack,
                            input logic [IDW-1:0] id, input logic valid,
                            input logic [N-1:0] yld);
    check({tag, "_ack"},   32'(bus_ack),     32'(ack));
    check({tag, "_id"},    32'(grant_id),    32'(id));
    check({tag, "_valid"}, 32'(grant_valid), 32'(valid));
    check({tag, "_yield"}, 32'(yield_req),   32'(yld));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus_req   = '0;
    htrans    = 2'b00;
    hready    = 1'b1;
    hmastlock = 1'b0;

    // Reset state
    #1;
    expect_out("reset", 3'b000, 2'd0, 1'b0, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request: one-cycle latency, grant_valid falls 2 cycles after drop
    bus_req = 3'b010;
    tick(); expect_out("s1_grant", 3'b010, 2'd1, 1'b1, 3'b000);
    bus_req = 3'b000;
    tick(); expect_out("s1_release", 3'b000, 2'd1, 1'b1, 3'b000);
    tick(); expect_out("s1_idle", 3'b000, 2'd1, 1'b0, 3'b000);

    // last_owner=1, all requesting: order 2,0,1,2 with a dead cycle between
    bus_req = 3'b111;
    begin
      logic [1:0] order [4];
      order = '{2'd2, 2'd0, 2'd1, 2'd2};
      for (int k = 0; k < 4; k++) begin
        tick(); expect_out($sformatf("s2_grant%0d", k), N'(1) << order[k], order[k], 1'b1, 3'b000);
        tick(); tick();
        bus_req[order[k]] = 1'b0;
        tick(); expect_out($sformatf("s2_rel%0d", k), 3'b000, order[k], 1'b1, 3'b000);
        bus_req[order[k]] = 1'b1;
        tick(); expect_out($sformatf("s2_dead%0d", k), 3'b000, order[k], 1'b0, 3'b000);
      end
    end
    bus_req = 3'b000;

    // Release held off by busy bus (htrans=NONSEQ, hready=0); last_owner=2
    bus_req = 3'b001;
    tick(); expect_out("s3_grant0", 3'b001, 2'd0, 1'b1, 3'b000);
    bus_req = 3'b010;
    htrans  = 2'b10;
    hready  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); expect_out($sformatf("s3_busy%0d", k), 3'b000, 2'd0, 1'b1, 3'b000);
    end
    htrans = 2'b00;
    hready = 1'b1;
    tick(); expect_out("s3_idle", 3'b000, 2'd0, 1'b0, 3'b000);
    tick(); expect_out("s3_grant1", 3'b010, 2'd1, 1'b1, 3'b000);
    bus_req = 3'b000;
    tick(); tick();

    // Hold limit: owner 0, req 2 rises at cycle 3; yield registered after cnt=8
    bus_req = 3'b001;
    tick(); expect_out("s4_grant0", 3'b001, 2'd0, 1'b1, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) bus_req = 3'b101;
      check($sformatf("s4_noyield%0d", k), 32'(yield_req), 32'd0);
    end
    tick(); expect_out("s4_yield", 3'b001, 2'd0, 1'b1, 3'b001);
    tick(); tick();
    expect_out("s4_yield_held", 3'b001, 2'd0, 1'b1, 3'b001);
    bus_req = 3'b100;
    tick(); expect_out("s4_release", 3'b000, 2'd0, 1'b1, 3'b000);
    tick();
    tick(); expect_out("s4_grant2", 3'b100, 2'd2, 1'b1, 3'b000);
    bus_req = 3'b000;
    tick(); tick();

    // Hold limit without other waiters: yield never rises
    bus_req = 3'b001;
    tick(); expect_out("s4b_grant0", 3'b001, 2'd0, 1'b1, 3'b000);
    for (int k = 0; k < 12; k++) tick();
    expect_out("s4b_noyield", 3'b001, 2'd0, 1'b1, 3'b000);
    bus_req = 3'b000;
    tick(); tick();

    // hmastlock suppresses yield and blocks RELEASE->IDLE; last_owner=0
    bus_req = 3'b010;
    tick(); expect_out("s5_grant1", 3'b010, 2'd1, 1'b1, 3'b000);
    hmastlock = 1'b1;
    bus_req   = 3'b011;
    for (int k = 0; k < 12; k++) tick();
    expect_out("s5_locked", 3'b010, 2'd1, 1'b1, 3'b000);
    bus_req = 3'b001;
    tick(); expect_out("s5_release", 3'b000, 2'd1, 1'b1, 3'b000);
    tick(); tick();
    expect_out("s5_lock_hold", 3'b000, 2'd1, 1'b1, 3'b000);
    hmastlock = 1'b0;
    tick(); expect_out("s5_idle", 3'b000, 2'd1, 1'b0, 3'b000);
    tick(); expect_out("s5_grant0", 3'b001, 2'd0, 1'b1, 3'b000);

    // Async reset while in GRANT with yield raised
    bus_req = 3'b011;
    for (int k = 0; k < 10; k++) tick();
    expect_out("s6_pre", 3'b001, 2'd0, 1'b1, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("s6_async", 3'b000, 2'd0, 1'b0, 3'b000);
    bus_req = 3'b111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); expect_out("s6_after", 3'b001, 2'd0, 1'b1, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
